uart_cmd_parser: RTL and testbench

- Receive-side counterpart of the ADC-to-UART string path.
- Consumes bytes delivered by the UART receiver and parses single-line ASCII commands:
  - "S" triggers an ADC conversion.
  - "Whh" writes a display byte.
  - "R" requests a re-send of the current ADC value.
- Drives one-cycle command pulses toward the SPI start logic, the FND display mux and the string transmitter.

---
 rtl/uart_cmd_parser_if.sv | 40 ++++
 rtl/uart_cmd_parser.sv | 187 ++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_parser_if.sv
// Byte-in / command-pulse-out bundle for the UART command parser.
// master drives received bytes, slave is the parser side.
interface uart_cmd_parser_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       adc_start;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       rd_req;
  logic       err;
  logic       busy;
  logic [7:0] echo_data;
  logic       echo_load;

  modport master (
    output rx_data,
    output rx_valid,
    input  adc_start,
    input  wr_data,
    input  wr_valid,
    input  rd_req,
    input  err,
    input  busy,
    input  echo_data,
    input  echo_load
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output adc_start,
    output wr_data,
    output wr_valid,
    output rd_req,
    output err,
    output busy,
    output echo_data,
    output echo_load
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// ASCII line parser for S / Whh / R commands from the UART receiver.
// Optional terminal echo of every received byte: UART_CMD_ECHO_EN.
module uart_cmd_parser #(
  parameter int unsigned TIMEOUT_CYC = 50000000,
  parameter int unsigned CNT_W       = 26
) (
  input logic              clk,
  input logic              n_rst,
  uart_cmd_parser_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, S_CR, R_CR, HEX_H, HEX_L, W_CR, FLUSH
  } state_t;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TIMEOUT_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       nib_h;
  logic [3:0]       nib_l;
  logic [7:0]       wr_data_q;
  logic             adc_q;
  logic             wr_q;
  logic             rd_q;
  logic             err_q;

  logic [7:0] b;
  logic [3:0] nib;
  logic       is_cr;
  logic       is_lf;
  logic       is_s;
  logic       is_r;
  logic       is_w;
  logic       is_hex;
  logic       expired;

  always_comb begin
    b      = bus.rx_data;
    is_cr  = (b == CR);
    is_lf  = (b == LF);
    is_s   = (b == 8'h53) || (b == 8'h73);
    is_r   = (b == 8'h52) || (b == 8'h72);
    is_w   = (b == 8'h57) || (b == 8'h77);
    is_hex = 1'b0;
    nib    = 4'h0;
    if (b >= 8'h30 && b <= 8'h39) begin
      is_hex = 1'b1;
      nib    = b[3:0];
    end else if ((b >= 8'h41 && b <= 8'h46) ||
                 (b >= 8'h61 && b <= 8'h66)) begin
      is_hex = 1'b1;
      nib    = b[3:0] + 4'd9;
    end
  end

  // >= so an LF landing on the expiry cycle only defers the abort
  assign expired = (cnt >= TO_LAST);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      nib_h     <= 4'h0;
      nib_l     <= 4'h0;
      wr_data_q <= 8'h00;
      adc_q     <= 1'b0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      adc_q <= 1'b0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      err_q <= 1'b0;
      cnt   <= (state == IDLE) ? '0 : cnt + CNT_W'(1);
      if (bus.rx_valid && !is_lf) begin
        cnt <= '0;
        unique case (state)
          IDLE: begin
            unique case (1'b1)
              is_s:    state <= S_CR;
              is_r:    state <= R_CR;
              is_w:    state <= HEX_H;
              is_cr:   state <= IDLE;
              default: state <= FLUSH;
            endcase
          end
          S_CR: begin
            if (is_cr) begin
              state <= IDLE;
              adc_q <= 1'b1;
            end else begin
              state <= FLUSH;
            end
          end
          R_CR: begin
            if (is_cr) begin
              state <= IDLE;
              rd_q  <= 1'b1;
            end else begin
              state <= FLUSH;
            end
          end
          HEX_H: begin
            unique case (1'b1)
              is_hex: begin
                nib_h <= nib;
                state <= HEX_L;
              end
              is_cr: begin
                state <= IDLE;
                err_q <= 1'b1;
              end
              default: state <= FLUSH;
            endcase
          end
          HEX_L: begin
            unique case (1'b1)
              is_hex: begin
                nib_l <= nib;
                state <= W_CR;
              end
              is_cr: begin
                state <= IDLE;
                err_q <= 1'b1;
              end
              default: state <= FLUSH;
            endcase
          end
          W_CR: begin
            if (is_cr) begin
              state     <= IDLE;
              wr_data_q <= {nib_h, nib_l};
              wr_q      <= 1'b1;
            end else begin
              state <= FLUSH;
            end
          end
          FLUSH: begin
            if (is_cr) begin
              state <= IDLE;
              err_q <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (!bus.rx_valid && state != IDLE && expired) begin
        state <= IDLE;
        err_q <= 1'b1;
        cnt   <= '0;
      end
    end
  end

  assign bus.adc_start = adc_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.wr_valid  = wr_q;
  assign bus.rd_req    = rd_q;
  assign bus.err       = err_q;
  assign bus.busy      = (state != IDLE);

`ifdef UART_CMD_ECHO_EN
  logic [7:0] echo_q;
  logic       echo_ld_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      echo_q    <= 8'h00;
      echo_ld_q <= 1'b0;
    end else begin
      echo_ld_q <= bus.rx_valid;
      if (bus.rx_valid) echo_q <= bus.rx_data;
    end
  end

  assign bus.echo_data = echo_q;
  assign bus.echo_load = echo_ld_q;
`else
  assign bus.echo_data = 8'h00;
  assign bus.echo_load = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser (TIMEOUT_CYC = 100).
// Define UART_CMD_ECHO_EN to also check the echo path.
module tb_uart_cmd_parser;

  localparam int K_ADC = 0;
  localparam int K_WR  = 1;
  localparam int K_RD  = 2;
  localparam int K_ERR = 3;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   echo_seen = 0;
  exp_t sb[$];
  logic [7:0] echo_exp[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  uart_cmd_parser_if bus ();

  uart_cmd_parser #(
    .TIMEOUT_CYC(100),
    .CNT_W(26)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .bus(bus)
  );

  always @(negedge clk) begin
    int   np;
    int   k;
    exp_t e;
    if (n_rst) begin
      np = int'(bus.adc_start) + int'(bus.wr_valid) +
           int'(bus.rd_req) + int'(bus.err);
      if (np > 0) begin
        vectors++;
        k = bus.adc_start ? K_ADC : bus.wr_valid ? K_WR :
            bus.rd_req ? K_RD : K_ERR;
        if (np > 1) begin
          miscompares++;
          $display("FAIL multi_pulse got %0d pulses exp 1 at cyc %0d",
                   np, cyc);
        end else if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_pulse got kind %0d exp none at cyc %0d",
                   k, cyc);
        end else begin
          e = sb.pop_front();
          if (k !== e.kind || cyc !== e.cyc ||
              (k == K_WR && bus.wr_data !== e.data)) begin
            miscompares++;
            $display("FAIL pulse got kind %0d cyc %0d data %02h exp kind %0d cyc %0d data %02h",
                     k, cyc, bus.wr_data, e.kind, e.cyc, e.data);
          end
        end
      end
      if (bus.echo_load) begin
        echo_seen++;
`ifdef UART_CMD_ECHO_EN
        vectors++;
        if (echo_exp.size() == 0) begin
          miscompares++;
          $display("FAIL echo_extra got %02h exp none", bus.echo_data);
        end else if (bus.echo_data !== echo_exp[0]) begin
          miscompares++;
          $display("FAIL echo_data got %02h exp %02h",
                   bus.echo_data, echo_exp[0]);
          void'(echo_exp.pop_front());
        end else begin
          void'(echo_exp.pop_front());
        end
`endif
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
`ifdef UART_CMD_ECHO_EN
    echo_exp.push_back(b);
`endif
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic expect_pulse(input int k, input logic [7:0] d,
                              input int dly);
    exp_t e;
    e.kind = k;
    e.data = d;
    e.cyc  = cyc + dly;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [28:0] o;
    idle(2);
    o = {bus.adc_start, bus.wr_valid, bus.rd_req, bus.err, bus.busy,
         bus.wr_data, bus.echo_load, bus.echo_data};
    vectors++;
    if (o !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got %h exp 0", o);
    end
    n_rst = 1'b1;
    idle(1);
  endtask

  task automatic test_adc;
    send_byte(8'h53);
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL adc_busy got %b exp 1", bus.busy);
    end
    expect_pulse(K_ADC, 8'h00, 1);
    send_byte(8'h0D);
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL adc_idle got %b exp 0", bus.busy);
    end
    idle(3);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL adc_pending got %0d exp 0", sb.size());
    end
  endtask

  task automatic test_write;
    send_byte(8'h77);
    send_byte(8'h33);
    send_byte(8'h66);
    expect_pulse(K_WR, 8'h3F, 1);
    send_byte(8'h0D);
    idle(2);
    vectors++;
    if (bus.wr_data !== 8'h3F) begin
      miscompares++;
      $display("FAIL wr_hold got %02h exp 3f", bus.wr_data);
    end
    send_byte(8'h57);
    send_byte(8'h41);
    send_byte(8'h35);
    expect_pulse(K_WR, 8'hA5, 1);
    send_byte(8'h0D);
    idle(2);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL wr_pending got %0d exp 0", sb.size());
    end
  endtask

  task automatic test_bad_line;
    send_byte(8'h57);
    send_byte(8'h47);
    send_byte(8'h31);
    expect_pulse(K_ERR, 8'h00, 1);
    send_byte(8'h0D);
    idle(2);
    vectors++;
    if (bus.wr_data !== 8'hA5) begin
      miscompares++;
      $display("FAIL bad_wr_data got %02h exp a5", bus.wr_data);
    end
    send_byte(8'h57);
    expect_pulse(K_ERR, 8'h00, 1);
    send_byte(8'h0D);
    idle(1);
    send_byte(8'h53);
    send_byte(8'h53);
    expect_pulse(K_ERR, 8'h00, 1);
    send_byte(8'h0D);
    idle(1);
    send_byte(8'h57);
    send_byte(8'h31);
    send_byte(8'h32);
    send_byte(8'h58);
    send_byte(8'h59);
    expect_pulse(K_ERR, 8'h00, 1);
    send_byte(8'h0D);
    idle(1);
    send_byte(8'h0D);
    send_byte(8'h72);
    expect_pulse(K_RD, 8'h00, 1);
    send_byte(8'h0D);
    idle(2);
    vectors++;
    if (sb.size() != 0 || bus.wr_data !== 8'hA5) begin
      miscompares++;
      $display("FAIL bad_pending got %0d/%02h exp 0/a5",
               sb.size(), bus.wr_data);
    end
  endtask

  task automatic test_back_to_back;
    expect_pulse(K_ADC, 8'h00, 2);
    send_byte(8'h73);
    send_byte(8'h0D);
    expect_pulse(K_RD, 8'h00, 2);
    send_byte(8'h52);
    send_byte(8'h0D);
    send_byte(8'h57);
    send_byte(8'h30);
    send_byte(8'h63);
    expect_pulse(K_WR, 8'h0C, 1);
    send_byte(8'h0D);
    idle(2);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_pending got %0d exp 0", sb.size());
    end
  endtask

  task automatic test_timeout;
    send_byte(8'h57);
    expect_pulse(K_ERR, 8'h00, 101);
    send_byte(8'h31);
    idle(98);
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL to_early got busy %b exp 1", bus.busy);
    end
    idle(10);
    vectors++;
    if (bus.busy !== 1'b0 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL to_abort got busy %b pend %0d exp 0 0",
               bus.busy, sb.size());
    end
    send_byte(8'h53);
    expect_pulse(K_ADC, 8'h00, 1);
    send_byte(8'h0D);
    send_byte(8'h57);
    idle(99);
    send_byte(8'h31);
    send_byte(8'h32);
    expect_pulse(K_WR, 8'h12, 1);
    send_byte(8'h0D);
    idle(2);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL to_pending got %0d exp 0", sb.size());
    end
  endtask

  task automatic test_reset_midline;
    logic [28:0] o;
    send_byte(8'h53);
    idle(1);
    n_rst = 1'b0;
    #1;
    o = {bus.adc_start, bus.wr_valid, bus.rd_req, bus.err, bus.busy,
         bus.wr_data, bus.echo_load, bus.echo_data};
    vectors++;
    if (o !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs got %h exp 0", o);
    end
    idle(2);
    n_rst = 1'b1;
    idle(1);
    send_byte(8'h0D);
    idle(3);
    vectors++;
    if (bus.busy !== 1'b0 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL midreset_after got busy %b pend %0d exp 0 0",
               bus.busy, sb.size());
    end
  endtask

  task automatic test_echo;
    int n0;
    n0 = echo_seen;
    send_byte(8'h52);
    send_byte(8'h0A);
    expect_pulse(K_RD, 8'h00, 1);
    send_byte(8'h0D);
    idle(2);
    vectors++;
`ifdef UART_CMD_ECHO_EN
    if (echo_seen - n0 != 3 || echo_exp.size() != 0) begin
      miscompares++;
      $display("FAIL echo_count got %0d left %0d exp 3 0",
               echo_seen - n0, echo_exp.size());
    end
`else
    if (echo_seen - n0 != 0 || bus.echo_data !== 8'h00) begin
      miscompares++;
      $display("FAIL echo_off got %0d/%02h exp 0/00",
               echo_seen - n0, bus.echo_data);
    end
`endif
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL echo_rd_pending got %0d exp 0", sb.size());
    end
  endtask

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    n_rst        = 1'b0;
    test_reset;
    test_adc;
    test_write;
    test_bad_line;
    test_back_to_back;
    test_timeout;
    test_reset_midline;
    test_echo;
    idle(2);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL final_pending got %0d exp 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
